player_button_ctrl: RTL

- Parametrised front-end for all music-player user buttons (play/pause, next, previous, stop, ...).
- Per channel it provides:
  - a 2-flop synchroniser
  - a debouncer
  - a press classifier (press / short-release / long-hold)
  - a level output, which is either a toggle (play/pause style) or momentary (follows the debounced button)
- Sits between raw board buttons and the player control logic; one instance serves every button.

---
 rtl/player_button_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/player_button_ctrl.sv
// Per-channel button front-end: sync, debounce, press/short/long classify.
// Level output is either a press toggle or the debounced button itself.
module player_button_ctrl #(
  parameter int               N_BTN             = 4,
  parameter int               DEBOUNCE_CYCLES   = 50000,
  parameter int               LONG_PRESS_CYCLES = 1000000,
  parameter logic [N_BTN-1:0] TOGGLE_MASK       = N_BTN'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_BTN-1:0] force_off,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] short_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] s;
  logic [N_BTN-1:0] db;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt, hcnt_n;
    state_t        st, st_n;
    logic          pr_n, sh_n, lg_n, lvl_n;
    logic          pr_q, sh_q, lg_q, lvl_q;

    // Any sample matching db restarts the stability count.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dcnt  <= '0;
        db[g] <= 1'b0;
      end else if (s[g] == db[g]) begin
        dcnt <= '0;
      end else if (dcnt == DMAX) begin
        db[g] <= s[g];
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end

    always_comb begin
      st_n   = st;
      hcnt_n = hcnt;
      pr_n   = 1'b0;
      sh_n   = 1'b0;
      lg_n   = 1'b0;
      unique case (st)
        IDLE: begin
          if (db[g]) begin
            st_n   = PRESSED;
            pr_n   = 1'b1;
            hcnt_n = '0;
          end
        end
        PRESSED: begin
          if (!db[g]) begin
            st_n = IDLE;
            sh_n = 1'b1;
          end else if (hcnt == HMAX) begin
            st_n = HELD;
            lg_n = 1'b1;
          end else if (hcnt != '1) begin
            hcnt_n = hcnt + 1'b1;
          end
        end
        HELD: begin
          if (!db[g]) st_n = IDLE;
        end
        default: st_n = IDLE;
      endcase
    end

    if (TOGGLE_MASK[g]) begin : g_tog
      always_comb begin
        lvl_n = lvl_q;
        if (force_off[g])
          lvl_n = 1'b0;
        else if (pr_n)
          lvl_n = ~lvl_q;
      end
    end else begin : g_mom
      always_comb lvl_n = db[g];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st    <= IDLE;
        hcnt  <= '0;
        pr_q  <= 1'b0;
        sh_q  <= 1'b0;
        lg_q  <= 1'b0;
        lvl_q <= 1'b0;
      end else begin
        st    <= st_n;
        hcnt  <= hcnt_n;
        pr_q  <= pr_n;
        sh_q  <= sh_n;
        lg_q  <= lg_n;
        lvl_q <= lvl_n;
      end
    end

    assign level[g]       = lvl_q;
    assign press_pulse[g] = pr_q;
    assign short_pulse[g] = sh_q;
    assign long_pulse[g]  = lg_q;
  end

endmodule
